// File: rtl/fir_unfolded_pkg.sv
// Shared sizing helpers and the scale/saturate step for the unfolded FIR filter.
// Pure functions and constants only; no state, no latency.
package fir_unfolded_pkg;

   localparam int DEF_LANES = 3;
   localparam int DEF_TAPS  = 5;
   localparam int DEF_WIDTH = 14;
   localparam int SAT_W     = 64;

   // Number of samples older than the input block that a full window still needs.
   function automatic int hist_len(input int taps);
      return taps - 1;
   endfunction

   function automatic int acc_width(input int width, input int taps);
      return 2 * width + $clog2(taps);
   endfunction

   // Q1.(width-1) rescale (floor) followed by clamp to the width-bit signed range.
   function automatic logic signed [SAT_W-1:0] sat_scale(input logic signed [SAT_W-1:0] acc,
                                                         input int width);
      logic signed [SAT_W-1:0] shifted;
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      shifted = acc >>> (width - 1);
      max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v   = -(64'sd1 <<< (width - 1));
      if (shifted > max_v) begin
         return max_v;
      end else if (shifted < min_v) begin
         return min_v;
      end
      return shifted;
   endfunction

endpackage

// File: rtl/fir_lane_mac.sv
// One output lane: TAPS-term signed dot product, Q1 rescale and saturation.
// Purely combinational; the caller registers the result and owns all flow control.
module fir_lane_mac
   import fir_unfolded_pkg::*;
#(
   parameter int TAPS  = DEF_TAPS,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [TAPS*WIDTH-1:0] win,
   input  logic [TAPS*WIDTH-1:0] coef,
   output logic [WIDTH-1:0]      y
);

   localparam int ACC_W  = acc_width(WIDTH, TAPS);
   localparam int PROD_W = 2 * WIDTH;

   logic [WIDTH-1:0]         c_s;
   logic [WIDTH-1:0]         x_s;
   logic signed [PROD_W-1:0] c_ext;
   logic signed [PROD_W-1:0] x_ext;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc;

   // win holds the oldest sample at slot 0, so b_i pairs with slot TAPS-1-i.
   always_comb begin
      c_s   = '0;
      x_s   = '0;
      c_ext = '0;
      x_ext = '0;
      prod  = '0;
      acc   = '0;
      for (int i = 0; i < TAPS; i++) begin
         c_s   = coef[i*WIDTH +: WIDTH];
         x_s   = win[(TAPS-1-i)*WIDTH +: WIDTH];
         c_ext = {{WIDTH{c_s[WIDTH-1]}}, c_s};
         x_ext = {{WIDTH{x_s[WIDTH-1]}}, x_s};
         prod  = c_ext * x_ext;
         acc   = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      end
      y = WIDTH'(sat_scale({{(SAT_W-ACC_W){acc[ACC_W-1]}}, acc}, WIDTH));
   end

endmodule

// File: rtl/fir_filter_unfolded_param.sv
// LANES-way unfolded FIR: input register, sample history, frozen coefficients, output register.
// Two-edge latency, one block per cycle; no backpressure, Vin gaps simply freeze the pipeline.
module fir_filter_unfolded_param
   import fir_unfolded_pkg::*;
#(
   parameter int LANES = DEF_LANES,
   parameter int TAPS  = DEF_TAPS,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                   Ck,
   input  logic                   Rst_n,
   input  logic                   Vin,
   input  logic [LANES*WIDTH-1:0] DIN,
   input  logic [TAPS*WIDTH-1:0]  B,
   output logic                   Vout,
   output logic [LANES*WIDTH-1:0] Dout
);

   localparam int HIST = hist_len(TAPS);
   localparam int WIN  = HIST + LANES;

   logic [LANES*WIDTH-1:0] in_q,   in_d;
   logic [HIST*WIDTH-1:0]  hist_q, hist_d;
   logic [TAPS*WIDTH-1:0]  coef_q, coef_d;
   logic [LANES*WIDTH-1:0] dout_q, dout_d;
   logic                   v1_q,   v1_d;
   logic                   vout_q, vout_d;

   logic [WIN*WIDTH-1:0]   win;
   logic [LANES*WIDTH-1:0] lane_y;

   // Oldest sample in the lowest slot: history first, then the current block.
   assign win = {in_q, hist_q};

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      fir_lane_mac #(
         .TAPS  (TAPS),
         .WIDTH (WIDTH)
      ) u_lane (
         .win  (win[j*WIDTH +: TAPS*WIDTH]),
         .coef (coef_q),
         .y    (lane_y[j*WIDTH +: WIDTH])
      );
   end

   always_comb begin
      v1_d   = Vin;
      in_d   = Vin ? DIN : in_q;
      hist_d = v1_q ? win[LANES*WIDTH +: HIST*WIDTH] : hist_q;
      vout_d = v1_q;
      dout_d = v1_q ? lane_y : dout_q;
      // Coefficients only move when nothing is in flight.
      coef_d = (!Vin && !v1_q) ? B : coef_q;
   end

   always_ff @(posedge Ck or negedge Rst_n) begin
      if (!Rst_n) begin
         in_q   <= '0;
         hist_q <= '0;
         coef_q <= '0;
         dout_q <= '0;
         v1_q   <= 1'b0;
         vout_q <= 1'b0;
      end else begin
         in_q   <= in_d;
         hist_q <= hist_d;
         coef_q <= coef_d;
         dout_q <= dout_d;
         v1_q   <= v1_d;
         vout_q <= vout_d;
      end
   end

   assign Vout = vout_q;
   assign Dout = dout_q;

endmodule

// File: doc/fir_filter_unfolded_param.md
# fir_filter_unfolded_param

Parametrised J-way unfolded FIR filter, the generalised successor of the fixed 3-lane, 5-tap, 14-bit unfolded filter. It processes LANES consecutive samples per clock through TAPS signed coefficients, with Q1.(WIDTH-1) scaling and output saturation. The input stream may pause through Vin gaps, and coefficients are frozen while data streams. It sits between read_input and write_output in the filter testbench and is the synthesis target for lane/tap exploration.

## Interface
- LANES, 3, samples processed per clock (unfolding factor J ≥ 1)
- TAPS, 5, number of coefficients b0..b(TAPS-1) (≥ 2)
- WIDTH, 14, sample, coefficient and output width (two's complement)
- Ck  in  1  clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Vin  in  1  block valid; DIN is sampled on Ck edges where Vin=1
- DIN  in  LANES*WIDTH  input block; lane j at bits [j*WIDTH +: WIDTH]; lane 0 is the oldest sample, x[J·k+0]
- B  in  TAPS*WIDTH  coefficients; b_i at [i*WIDTH +: WIDTH]
- Vout  out  1  output block valid
- Dout  out  LANES*WIDTH  output block; lane j carries y[J·k+j]

## Operation
- Filter: y[n] = Σ_{i=0}^{TAPS-1} b_i·x[n−i]. Samples with n<0 after reset are 0.
- Stage 1 (input register): on an edge with Vin=1, DIN goes to the input register and v1 is set to 1. On an edge with Vin=0, v1 is cleared and the input register holds its value.
- History: a register holds the TAPS−1 most recent samples older than the input register. It advances by LANES samples on each edge where v1=1 and is frozen otherwise. Both TAPS−1 > LANES and TAPS−1 ≤ LANES must work.
- Stage 2 (output register): on edges with v1=1, Dout takes the LANES filter results and Vout is set to 1. When v1=0, Vout goes to 0 and Dout holds its last value.
- Coefficient register: loads B on every edge where Vin=0 and v1=0 (idle). It holds while streaming, so B changes during a burst have no effect until the pipeline is idle.
- Arithmetic per lane:
  - Products are full 2·WIDTH signed.
  - The accumulator is 2·WIDTH+clog2(TAPS) bits and does not overflow.
  - The result is accumulator >>> (WIDTH−1), arithmetic shift, truncating toward −∞.
  - The result then saturates to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Reset (asynchronous, any time):
  - input register, history, coefficient register, v1, Vout and Dout all go to 0 immediately.
  - After release the filter starts from zero initial conditions.
  - The coefficient register reloads on the first idle edge.

## Timing
- Latency: with Vin=1 at edge E, Vout=1 and the corresponding Dout appear after edge E+1. This is a fixed 2-edge pipeline with throughput of one block per cycle.
- Vout is Vin delayed by two edges, exactly, including gaps.
- Back-to-back Vin=1 bursts need no idle cycles between them.
- The output sequence is independent of gap placement. It depends only on the order of valid blocks.
- Vin=1 and a B change on the same edge: B is ignored (coefficients are not idle).
- Vin must be low for at least one edge after Rst_n release so that coefficients load. The bench guarantees this.

## Structure
- Package fir_unfolded_pkg holds:
  - function acc_width(WIDTH, TAPS)
  - function sat_scale(acc, WIDTH), which does the shift and saturation
  - a localparam for the history length, TAPS−1
- Sub-module fir_lane_mac: one lane's TAPS-term dot product, scaling and saturation (combinational). The top instantiates it LANES times, with lane j taking window samples x[J·k+j−TAPS+1 .. J·k+j] from the history and the input register.
- The top contains the input, history, coefficient and output registers plus the valid pipeline.

## Test plan
- Impulse: LANES=3, TAPS=5, WIDTH=14, B={1000,2000,3000,4000,5000}, block0 = {4096,0,0} then zeros.
  - Block0 out = {500,1000,1500}, block1 out = {2000,2500,0}, then zeros.
  - Vout rises after the second edge following Vin.
- Saturation, positive: all b=8191, x=8191 constant → every lane outputs 8191 once history fills.
- Saturation, negative: all b=8191, x=−8192 constant → every lane outputs −8192.
- Gaps: a 10-block random stream with Vin low for 3 cycles after block 4.
  - Dout values equal the gapless golden sequence.
  - Vout is low for exactly 3 cycles, and Dout holds during the gap.
- Coefficient freeze: change B to all-zero mid-burst → outputs are unchanged until the burst ends. After one idle edge, the next burst outputs 0.
- Reset mid-stream: drop Rst_n between edges.
  - Vout and Dout are 0 immediately, without a clock.
  - After release plus one idle edge, the impulse test reproduces its exact outputs.
- Parameter sweep: (LANES=1,TAPS=5), (LANES=4,TAPS=3), (LANES=2,TAPS=8,WIDTH=16) → bit-exact against the golden model on 1000 random samples.
